// File: rtl/grf_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : grf_wb_pkg
// Purpose  : Shared constants for the write-back / register-file slice.
//            REG_ZERO   - index of the hard-wired zero register
//            BUBBLE_PC  - PC value that marks a pipeline bubble
//            *_DEF      - default widths for data, index and retire counter
// Revision : 1.0  initial release
// ============================================================================
package grf_wb_pkg;
    localparam int          DATA_W_DEF = 32;
    localparam int          ADDR_W_DEF = 5;
    localparam int          CNT_W_DEF  = 32;
    localparam logic [4:0]  REG_ZERO   = 5'd0;
    localparam logic [31:0] BUBBLE_PC  = 32'h0;
endpackage
`default_nettype wire

// File: rtl/grf_wb_retire_tracker.sv
`default_nettype none
// ============================================================================
// Module   : retire_tracker
// Purpose  : Registered one-cycle retire trace and retired-instruction counter.
// Ports    : clk, reset (async, active-low)
//            RegWrite_W, WR_W, WD_W, PC_W  - write-back stage inputs
//            trace_valid/pc/reg/data       - trace of the write seen last edge
//            retire_cnt                    - count of non-bubble PCs, wraps
// Revision : 1.0  initial release
// ============================================================================
module retire_tracker
    import grf_wb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWrite_W,
    input  logic [ADDR_W-1:0] WR_W,
    input  logic [DATA_W-1:0] WD_W,
    input  logic [31:0]       PC_W,
    output logic              trace_valid,
    output logic [31:0]       trace_pc,
    output logic [ADDR_W-1:0] trace_reg,
    output logic [DATA_W-1:0] trace_data,
    output logic [CNT_W-1:0]  retire_cnt
);

    logic              r_valid;
    logic [31:0]       r_pc;
    logic [ADDR_W-1:0] r_reg;
    logic [DATA_W-1:0] r_data;
    logic [CNT_W-1:0]  r_cnt;

    // Trace fields capture every enabled write, including writes to $0,
    // so the trace reflects what the pipeline attempted rather than what
    // the file actually stored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_reg   <= '0;
            r_data  <= '0;
        end else begin
            r_valid <= RegWrite_W;
            if (RegWrite_W) begin
                r_pc   <= PC_W;
                r_reg  <= WR_W;
                r_data <= WD_W;
            end
        end
    end

    // Retirement is keyed on the PC, not the write enable, so stores and
    // branches count too. Natural overflow provides the wrap to zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (PC_W != BUBBLE_PC) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign trace_valid = r_valid;
    assign trace_pc    = r_pc;
    assign trace_reg   = r_reg;
    assign trace_data  = r_data;
    assign retire_cnt  = r_cnt;

endmodule
`default_nettype wire

// File: rtl/grf_wb.sv
`default_nettype none
// ============================================================================
// Module   : grf_wb
// Purpose  : Write-back stage: general register file with write-first bypass
//            on both decode read ports, plus retire trace / counter.
// Ports    : clk, reset (async, active-low)
//            A1, A2 / RD1, RD2       - decode read ports (RDn combinational)
//            WD_W, WR_W, RegWrite_W  - write-back write port
//            PC_W                    - PC in write-back, 0 = bubble
//            trace_*, retire_cnt     - debug trace outputs
// Revision : 1.0  initial release
// ============================================================================
module grf_wb
    import grf_wb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] A1,
    input  logic [ADDR_W-1:0] A2,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2,
    input  logic [DATA_W-1:0] WD_W,
    input  logic [ADDR_W-1:0] WR_W,
    input  logic              RegWrite_W,
    input  logic [31:0]       PC_W,
    output logic              trace_valid,
    output logic [31:0]       trace_pc,
    output logic [ADDR_W-1:0] trace_reg,
    output logic [DATA_W-1:0] trace_data,
    output logic [CNT_W-1:0]  retire_cnt
);

    localparam int          NREGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

    // Entry 0 exists only to keep indexing simple; it is reset and never
    // written, and reads of index 0 are forced to zero anyway.
    logic [DATA_W-1:0] r_regs [NREGS];

    logic w_wr_en;
    assign w_wr_en = RegWrite_W && (WR_W != ZERO_IDX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[WR_W] <= WD_W;
        end
    end

    // Write-first bypass: a write presented this cycle is visible to decode
    // immediately, so no separate forwarding path is needed from WB to ID.
    always_comb begin
        RD1 = r_regs[A1];
        if (A1 == ZERO_IDX) begin
            RD1 = '0;
        end else if (RegWrite_W && (WR_W == A1)) begin
            RD1 = WD_W;
        end
    end

    always_comb begin
        RD2 = r_regs[A2];
        if (A2 == ZERO_IDX) begin
            RD2 = '0;
        end else if (RegWrite_W && (WR_W == A2)) begin
            RD2 = WD_W;
        end
    end

    retire_tracker #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_retire_tracker (
        .clk         (clk),
        .reset       (reset),
        .RegWrite_W  (RegWrite_W),
        .WR_W        (WR_W),
        .WD_W        (WD_W),
        .PC_W        (PC_W),
        .trace_valid (trace_valid),
        .trace_pc    (trace_pc),
        .trace_reg   (trace_reg),
        .trace_data  (trace_data),
        .retire_cnt  (retire_cnt)
    );

endmodule
`default_nettype wire

// File: tb/tb_grf_wb.sv
`default_nettype none
// ============================================================================
// Module   : tb_grf_wb
// Purpose  : Self-checking bench for grf_wb. A second instance with a 2-bit
//            retire counter exercises the counter wrap.
// Revision : 1.0  initial release
// ============================================================================
module tb_grf_wb;

    logic        clk;
    logic        reset;
    logic [4:0]  A1, A2, WR_W;
    logic [31:0] WD_W, PC_W;
    logic        RegWrite_W;

    logic [31:0] RD1, RD2, trace_pc, trace_data, retire_cnt;
    logic [4:0]  trace_reg;
    logic        trace_valid;

    logic [31:0] w_RD1, w_RD2, w_trace_pc, w_trace_data;
    logic [4:0]  w_trace_reg;
    logic        w_trace_valid;
    logic [1:0]  w_retire_cnt;

    int checks = 0;
    int errors = 0;

    grf_wb dut (
        .clk(clk), .reset(reset), .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2),
        .WD_W(WD_W), .WR_W(WR_W), .RegWrite_W(RegWrite_W), .PC_W(PC_W),
        .trace_valid(trace_valid), .trace_pc(trace_pc), .trace_reg(trace_reg),
        .trace_data(trace_data), .retire_cnt(retire_cnt)
    );

    grf_wb #(.CNT_W(2)) dut_wrap (
        .clk(clk), .reset(reset), .A1(A1), .A2(A2), .RD1(w_RD1), .RD2(w_RD2),
        .WD_W(WD_W), .WR_W(WR_W), .RegWrite_W(RegWrite_W), .PC_W(PC_W),
        .trace_valid(w_trace_valid), .trace_pc(w_trace_pc), .trace_reg(w_trace_reg),
        .trace_data(w_trace_data), .retire_cnt(w_retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic [31:0] pc;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [31:0] e_rd1;
        logic [31:0] e_rd2;
        logic        e_tv;
        logic [31:0] e_tpc;
        logic [4:0]  e_treg;
        logic [31:0] e_tdata;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs [11];

    initial begin
        //          we  wr     wd            pc          a1     a2     rd1           rd2           tv   tpc         treg   tdata         cnt
        vecs[0]  = '{1'b1, 5'd8,  32'hDEADBEEF, 32'h3000, 5'd8,  5'd0,  32'hDEADBEEF, 32'h0,        1'b1, 32'h3000, 5'd8,  32'hDEADBEEF, 32'd1};
        vecs[1]  = '{1'b0, 5'd0,  32'h0,        32'h0,    5'd8,  5'd9,  32'hDEADBEEF, 32'h0,        1'b0, 32'h3000, 5'd8,  32'hDEADBEEF, 32'd1};
        vecs[2]  = '{1'b1, 5'd5,  32'h1234,     32'h3004, 5'd5,  5'd5,  32'h1234,     32'h1234,     1'b1, 32'h3004, 5'd5,  32'h1234,     32'd2};
        vecs[3]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 32'h3008, 5'd0,  5'd5,  32'h0,        32'h1234,     1'b1, 32'h3008, 5'd0,  32'hFFFFFFFF, 32'd3};
        vecs[4]  = '{1'b0, 5'd0,  32'h0,        32'h0,    5'd0,  5'd8,  32'h0,        32'hDEADBEEF, 1'b0, 32'h3008, 5'd0,  32'hFFFFFFFF, 32'd3};
        vecs[5]  = '{1'b0, 5'd0,  32'h0,        32'h0,    5'd5,  5'd0,  32'h1234,     32'h0,        1'b0, 32'h3008, 5'd0,  32'hFFFFFFFF, 32'd3};
        vecs[6]  = '{1'b0, 5'd0,  32'h0,        32'h0,    5'd8,  5'd5,  32'hDEADBEEF, 32'h1234,     1'b0, 32'h3008, 5'd0,  32'hFFFFFFFF, 32'd3};
        vecs[7]  = '{1'b0, 5'd8,  32'h55555555, 32'h300C, 5'd8,  5'd8,  32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 32'h3008, 5'd0,  32'hFFFFFFFF, 32'd4};
        vecs[8]  = '{1'b1, 5'd8,  32'h0A0A0A0A, 32'h3010, 5'd8,  5'd9,  32'h0A0A0A0A, 32'h0,        1'b1, 32'h3010, 5'd8,  32'h0A0A0A0A, 32'd5};
        vecs[9]  = '{1'b1, 5'd31, 32'hCAFEF00D, 32'h3014, 5'd31, 5'd8,  32'hCAFEF00D, 32'h0A0A0A0A, 1'b1, 32'h3014, 5'd31, 32'hCAFEF00D, 32'd6};
        vecs[10] = '{1'b0, 5'd0,  32'h0,        32'h0,    5'd0,  5'd31, 32'h0,        32'hCAFEF00D, 1'b0, 32'h3014, 5'd31, 32'hCAFEF00D, 32'd6};

        reset = 1'b0;
        A1 = 5'd3; A2 = 5'd31; WR_W = 5'd0; WD_W = 32'h0; PC_W = 32'h0; RegWrite_W = 1'b0;
        #1;
        chk("reset_rd1", RD1, 32'h0);
        chk("reset_tv", {31'h0, trace_valid}, 32'h0);
        chk("reset_cnt", retire_cnt, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++) begin
            RegWrite_W = vecs[i].we; WR_W = vecs[i].wr; WD_W = vecs[i].wd;
            PC_W = vecs[i].pc; A1 = vecs[i].a1; A2 = vecs[i].a2;
            @(negedge clk);
            chk($sformatf("v%0d_rd1", i), RD1, vecs[i].e_rd1);
            chk($sformatf("v%0d_rd2", i), RD2, vecs[i].e_rd2);
            @(posedge clk); #1;
            chk($sformatf("v%0d_tv", i), {31'h0, trace_valid}, {31'h0, vecs[i].e_tv});
            chk($sformatf("v%0d_tpc", i), trace_pc, vecs[i].e_tpc);
            chk($sformatf("v%0d_treg", i), {27'h0, trace_reg}, {27'h0, vecs[i].e_treg});
            chk($sformatf("v%0d_tdata", i), trace_data, vecs[i].e_tdata);
            chk($sformatf("v%0d_cnt", i), retire_cnt, vecs[i].e_cnt);
            chk($sformatf("v%0d_cnt2", i), {30'h0, w_retire_cnt}, vecs[i].e_cnt % 4);
        end

        // Asynchronous reset mid-run with a write pending.
        RegWrite_W = 1'b1; WR_W = 5'd7; WD_W = 32'h77; PC_W = 32'h3020; A1 = 5'd8; A2 = 5'd31;
        @(posedge clk); #1;
        chk("pre_rst_tv", {31'h0, trace_valid}, 32'h1);
        chk("pre_rst_cnt", retire_cnt, 32'd7);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_rd1", RD1, 32'h0);
        chk("async_rst_rd2", RD2, 32'h0);
        chk("async_rst_tv", {31'h0, trace_valid}, 32'h0);
        chk("async_rst_tpc", trace_pc, 32'h0);
        chk("async_rst_tdata", trace_data, 32'h0);
        chk("async_rst_cnt", retire_cnt, 32'h0);
        @(posedge clk); #1;
        RegWrite_W = 1'b0; PC_W = 32'h0; A1 = 5'd7;
        #1;
        chk("rst_discard_wr", RD1, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_cnt", retire_cnt, 32'h0);
        RegWrite_W = 1'b1; WR_W = 5'd7; WD_W = 32'h99; PC_W = 32'h4000;
        @(posedge clk); #1;
        RegWrite_W = 1'b0; PC_W = 32'h0;
        #1;
        chk("first_wr_rd1", RD1, 32'h99);
        chk("first_wr_cnt", retire_cnt, 32'd1);
        chk("first_wr_tpc", trace_pc, 32'h4000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/grf_wb.md
# grf_wb

Write-back stage block of the five-stage MIPS pipeline. It consumes the memory/write-back pipeline register outputs (write data, destination register, write enable, PC), holds the 32×32 general register file, and serves the decode stage's two read ports with internal write-first bypass. It also emits a registered one-cycle retire trace and a retired-instruction counter for the testbench and debug.

## Interface
Parameters:
- DATA_W, 32, register and data width
- ADDR_W, 5, register index width (2^ADDR_W registers)
- CNT_W, 32, retire counter width

Ports:
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low reset; one clock, reset is asynchronous and active-low
- A1  in  ADDR_W  decode read port 1 index (rs)
- A2  in  ADDR_W  decode read port 2 index (rt)
- RD1  out  DATA_W  read data port 1, combinational
- RD2  out  DATA_W  read data port 2, combinational
- WD_W  in  DATA_W  write-back data
- WR_W  in  ADDR_W  write-back destination index
- RegWrite_W  in  1  write enable
- PC_W  in  32  PC of the instruction in write-back; 0 marks a bubble
- trace_valid  out  1  one-cycle pulse: a write was committed last edge
- trace_pc  out  32  PC of the traced write
- trace_reg  out  ADDR_W  destination of the traced write
- trace_data  out  DATA_W  data of the traced write
- retire_cnt  out  CNT_W  count of retired non-bubble instructions

## Operation
- Register file: 2^ADDR_W entries; entry 0 is constant zero, never written, always reads 0.
- Write: on rising edge, if RegWrite_W=1 and WR_W≠0, reg[WR_W] <= WD_W.
- Read: RDn = 0 if An=0; else WD_W if RegWrite_W=1 and WR_W=An (write-first bypass); else reg[An]. Both ports bypass independently; A1=A2 is legal.
- Trace: on every edge, trace_valid <= RegWrite_W; when RegWrite_W=1, trace_pc/trace_reg/trace_data <= PC_W/WR_W/WD_W, including WR_W=0 (traced, file unchanged). When RegWrite_W=0, trace_pc/reg/data hold previous values.
- Retire counter: increments by 1 on each edge where PC_W≠0, regardless of RegWrite_W; wraps 2^CNT_W−1 -> 0.
- Reset (reset=0): immediately, asynchronously, all registers 1..31 = 0, trace_valid=0, trace_pc=0, trace_reg=0, trace_data=0, retire_cnt=0. RD1/RD2 then reflect zeroed file plus bypass term. Reset mid-operation discards any write presented in that cycle; first write accepted on the first rising edge with reset=1.

## Timing
- Write latency: visible in reg array one edge after presentation; visible on RD ports the same cycle via bypass.
- Trace latency: 1 cycle after the write-back cycle.
- Retire counter: updated 1 cycle after the write-back cycle.
- No backpressure; block accepts one write-back per cycle unconditionally.
- Reset release is synchronised by the system; no internal synchroniser.

## Structure
- Shared package: REG_ZERO (5'd0), BUBBLE_PC (32'h0), DATA_W/ADDR_W defaults.
- Sub-module retire_tracker: trace registers and retire counter (inputs RegWrite_W, WR_W, WD_W, PC_W); grf_wb holds the array and read/bypass logic.

## Test plan
- Reset: drive reset=0 mid-run after writes -> all reads 0, retire_cnt=0, trace_valid=0 without waiting for a clock edge.
- Write/read: write $8 <= 32'hDEADBEEF at PC 32'h3000 -> next cycle RD1(A1=8)=32'hDEADBEEF, trace_valid=1, trace_pc=32'h3000, trace_reg=8, retire_cnt=1.
- Bypass: RegWrite_W=1, WR_W=5, WD_W=32'h1234, A1=A2=5 same cycle -> RD1=RD2=32'h1234 before the edge.
- $0: write WR_W=0, WD_W=32'hFFFFFFFF -> RD1(A1=0)=0 in and after cycle; trace_valid=1, trace_reg=0, trace_data=32'hFFFFFFFF.
- Bubble: PC_W=0, RegWrite_W=0 for 3 cycles -> retire_cnt unchanged, trace_valid=0, trace fields hold prior values.
- Wrap: force retire_cnt to 32'hFFFFFFFF, present PC_W=32'h3004 -> retire_cnt=0.
